display_multiplexado: RTL



---
 rtl/display_multiplexado_if.sv | 32 +++
 rtl/display_multiplexado.sv | 134 +++++++++++++
 2 files changed

// File: rtl/display_multiplexado_if.sv
// rtl/display_multiplexado_if.sv - digit data, control and pin bundle of the multiplexed display driver
//
// Signals:
//   dados        packed digits, [3:0] is digit 0 (rightmost)
//   carregar     load strobe for the shadow register
//   modo_hex     1 = hexadecimal decode, 0 = decimal decode
//   apagar_zeros leading-zero blanking enable
//   piscar       per-digit blink enable
//   segmentos    segment pins {a,b,c,d,e,f,g}
//   anodos       one-hot digit enable pins
// master: the control logic driving the display; slave: the display driver.
interface display_multiplexado_if #(
    parameter int N_DIGITOS = 4
);
    logic [4*N_DIGITOS-1:0] dados;
    logic                   carregar;
    logic                   modo_hex;
    logic                   apagar_zeros;
    logic [N_DIGITOS-1:0]   piscar;
    logic [6:0]             segmentos;
    logic [N_DIGITOS-1:0]   anodos;

    modport master (
        output dados, carregar, modo_hex, apagar_zeros, piscar,
        input  segmentos, anodos
    );

    modport slave (
        input  dados, carregar, modo_hex, apagar_zeros, piscar,
        output segmentos, anodos
    );
endinterface

// File: rtl/display_multiplexado.sv
// rtl/display_multiplexado.sv - time-multiplexed N-digit 7-segment display driver
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    display_multiplexado_if.slave: dados/carregar/modo_hex/apagar_zeros/piscar in,
//          segmentos/anodos out (both registered)
// Each digit is held for DIV_VARREDURA cycles: one dead cycle with everything off,
// then DIV_VARREDURA-1 lit cycles. Digits blink with a half-period of QUADROS_PISCA frames.
module display_multiplexado #(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int QUADROS_PISCA = 64,
    parameter int ATIVO_BAIXO   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    display_multiplexado_if.slave   bus
);
    localparam int CW = $clog2(DIV_VARREDURA);
    localparam int DW = $clog2(N_DIGITOS);
    localparam int QW = (QUADROS_PISCA > 1) ? $clog2(QUADROS_PISCA) : 1;

    localparam logic [CW-1:0] CONT_MAX   = CW'(DIV_VARREDURA - 1);
    localparam logic [DW-1:0] DIG_MAX    = DW'(N_DIGITOS - 1);
    localparam logic [QW-1:0] QUADRO_MAX = QW'(QUADROS_PISCA - 1);

    logic [4*N_DIGITOS-1:0] shadow;
    logic [CW-1:0]          cont;
    logic [DW-1:0]          dig;
    logic [QW-1:0]          quadro;
    logic                   fase;

    // Logical (active-high) output registers; polarity is applied after them.
    logic [6:0]             seg_q;
    logic [N_DIGITOS-1:0]   an_q;

    logic [6:0]             seg_next;
    logic [N_DIGITOS-1:0]   an_next;
    logic [3:0]             digitos [N_DIGITOS];
    logic [N_DIGITOS-1:0]   zero_acima;

    function automatic logic [6:0] decodifica(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1110011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        // Decimal mode shows nothing for the letter codes.
        if (!hex && v > 4'h9) begin
            s = 7'b0000000;
        end
        return s;
    endfunction

    // zero_acima[i] = digit i and every digit above it are zero.
    always_comb begin
        for (int i = 0; i < N_DIGITOS; i++) begin
            digitos[i] = shadow[4*i +: 4];
        end
        zero_acima = '0;
        zero_acima[N_DIGITOS-1] = (digitos[N_DIGITOS-1] == 4'h0);
        for (int i = N_DIGITOS - 2; i >= 0; i--) begin
            zero_acima[i] = zero_acima[i+1] && (digitos[i] == 4'h0);
        end
    end

    always_comb begin
        seg_next = 7'b0000000;
        an_next  = '0;
        if (cont != '0) begin
            an_next[dig] = 1'b1;
            seg_next     = decodifica(digitos[dig], bus.modo_hex);
            // Digit 0 is exempt so an all-zero value still shows "0".
            if (bus.apagar_zeros && (dig != '0) && zero_acima[dig]) begin
                seg_next = 7'b0000000;
            end
            if (fase && bus.piscar[dig]) begin
                seg_next = 7'b0000000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            cont   <= '0;
            dig    <= '0;
            quadro <= '0;
            fase   <= 1'b0;
            seg_q  <= '0;
            an_q   <= '0;
        end else begin
            if (bus.carregar) begin
                shadow <= bus.dados;
            end
            seg_q <= seg_next;
            an_q  <= an_next;
            if (cont == CONT_MAX) begin
                cont <= '0;
                if (dig == DIG_MAX) begin
                    dig <= '0;
                    if (quadro == QUADRO_MAX) begin
                        quadro <= '0;
                        fase   <= ~fase;
                    end else begin
                        quadro <= quadro + 1'b1;
                    end
                end else begin
                    dig <= dig + 1'b1;
                end
            end else begin
                cont <= cont + 1'b1;
            end
        end
    end

    assign bus.segmentos = (ATIVO_BAIXO != 0) ? ~seg_q : seg_q;
    assign bus.anodos    = (ATIVO_BAIXO != 0) ? ~an_q  : an_q;
endmodule
